// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin scheduler draining NUM_Q first-word-fall-through FIFOs into one
// registered valid/ready output stream. Each grant pops a burst of up to BURST_MAX beats.
// A burst ends early when the FIFO runs dry (aempty on the popped beat, or empty while
// accepting). Every burst end returns to IDLE, which costs one bubble cycle on ren_o.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   empty_i     per-FIFO empty flags (bit q -> FIFO q)
//   aempty_i    per-FIFO almost-empty flags (FIFO holds exactly one entry)
//   rdata_i     per-FIFO head data, slice q = [q*DATA_WIDTH +: DATA_WIDTH]
//   ren_o       per-FIFO pop strobe, at most one bit set
//   m_valid_o / m_ready_i / m_data_o / m_qid_o / m_last_o  registered output stream
//   busy_o      high while a grant is active
//
// Optional build macro: FIFO_RR_SCHED_PRIO_Q0_EN gives queue 0 strict priority at burst
// boundaries; its grants leave rr_ptr untouched so the other queues keep their rotation.
module fifo_rr_sched #(
  parameter int unsigned NUM_Q      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned QID_WIDTH  = $clog2(NUM_Q)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_Q-1:0]            empty_i,
  input  logic [NUM_Q-1:0]            aempty_i,
  input  logic [NUM_Q*DATA_WIDTH-1:0] rdata_i,
  output logic [NUM_Q-1:0]            ren_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic [QID_WIDTH-1:0]        m_qid_o,
  output logic                        m_last_o,
  output logic                        busy_o
);

  localparam int unsigned CntWidth = $clog2(BURST_MAX + 1);
  localparam logic [CntWidth-1:0]  BurstMaxCnt = CntWidth'(BURST_MAX);
  localparam logic [QID_WIDTH-1:0] LastQ = QID_WIDTH'(NUM_Q - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                state_q;
  logic [QID_WIDTH-1:0]  rr_ptr_q;
  logic [QID_WIDTH-1:0]  grant_q;
  logic [CntWidth-1:0]   beat_cnt_q;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [QID_WIDTH-1:0]  m_qid_q;
  logic                  m_last_q;

  logic [DATA_WIDTH-1:0] rdata_arr [NUM_Q];
  logic                  accept;
  logic                  pop;
  logic                  grant_empty;
  logic [CntWidth-1:0]   cnt_next;
  logic                  last_next;
  logic                  found;
  logic [QID_WIDTH-1:0]  pick;
  logic [QID_WIDTH-1:0]  pick_next;
  logic                  prio_q0;

  always_comb begin
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      rdata_arr[q] = rdata_i[q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The output register may load whenever it is empty or being drained this cycle.
  assign accept      = !m_valid_q || m_ready_i;
  assign grant_empty = empty_i[grant_q];
  assign pop         = (state_q == StGrant) && accept && !grant_empty;
  assign cnt_next    = beat_cnt_q + 1'b1;
  assign last_next   = (cnt_next == BurstMaxCnt) || aempty_i[grant_q];

  always_comb begin
    ren_o = '0;
    if (pop) begin
      ren_o[grant_q] = 1'b1;
    end
  end

  // First non-empty queue at or after rr_ptr, wrapping modulo NUM_Q.
  always_comb begin
    logic [QID_WIDTH-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      idx = QID_WIDTH'((32'(rr_ptr_q) + i) % NUM_Q);
      if (!found && !empty_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_next = (pick == LastQ) ? '0 : pick + 1'b1;

`ifdef FIFO_RR_SCHED_PRIO_Q0_EN
  assign prio_q0 = !empty_i[0];
`else
  assign prio_q0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_qid_q    <= '0;
      m_last_q   <= 1'b0;
    end else begin
      if (accept) begin
        m_valid_q <= pop;
        if (pop) begin
          m_data_q <= rdata_arr[grant_q];
          m_qid_q  <= grant_q;
          m_last_q <= last_next;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (prio_q0) begin
            grant_q    <= '0;
            beat_cnt_q <= '0;
            state_q    <= StGrant;
          end else if (found) begin
            grant_q    <= pick;
            rr_ptr_q   <= pick_next;
            beat_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (pop) begin
            beat_cnt_q <= cnt_next;
            if (last_next) begin
              state_q <= StIdle;
            end
          end else if (accept && grant_empty) begin
            // Source ran dry without a final-beat mark; close the burst.
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_qid_o   = m_qid_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = (state_q == StGrant);

endmodule

// File: tb/tb_fifo_rr_sched.sv
module tb_fifo_rr_sched;
  localparam int NQ = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int QW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NQ-1:0]    empty_i;
  logic [NQ-1:0]    aempty_i;
  logic [NQ*DW-1:0] rdata_i;
  logic [NQ-1:0]    ren_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [DW-1:0]    m_data_o;
  logic [QW-1:0]    m_qid_o;
  logic             m_last_o;
  logic             busy_o;

  always #5 clk = ~clk;

  fifo_rr_sched #(
    .NUM_Q      (NQ),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .empty_i   (empty_i),
    .aempty_i  (aempty_i),
    .rdata_i   (rdata_i),
    .ren_o     (ren_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_qid_o   (m_qid_o),
    .m_last_o  (m_last_o),
    .busy_o    (busy_o)
  );

  // FIFO contents (model of the source FIFOs) and per-queue scoreboard of expected beats.
  logic [DW-1:0] fifo_m [NQ][$];
  logic [DW-1:0] exp_d  [NQ][$];
  logic [QW-1:0] exp_qid [$];
  logic          exp_last [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int q = 0; q < NQ; q++) begin
      logic [DW-1:0] head;
      head = (fifo_m[q].size() != 0) ? fifo_m[q][0] : '0;
      empty_i[q]  = (fifo_m[q].size() == 0);
      aempty_i[q] = (fifo_m[q].size() == 1);
      rdata_i[q*DW +: DW] = head;
    end
  endtask

  task automatic load(input int q, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_m[q].push_back(base + DW'(i));
      exp_d[q].push_back(base + DW'(i));
    end
    drive();
    #1;
  endtask

  task automatic push_beats(input logic [QW-1:0] q, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      exp_qid.push_back(q);
      exp_last.push_back(last && (i == n - 1));
    end
  endtask

  // One clock: compare any handshake at the negedge, then apply FIFO pops after the posedge.
  task automatic cycle();
    logic [NQ-1:0] ren_s;
    logic [QW-1:0] qid;
    @(negedge clk);
    ren_s = ren_o;
    check("ren_onehot0", 32'($onehot0(ren_o)), 32'd1);
    if (m_valid_o && m_ready_i) begin
      qid = m_qid_o;
      if (exp_d[qid].size() == 0) begin
        check("unexpected_beat", 32'(qid), 32'hffff);
      end else begin
        check("data", m_data_o, exp_d[qid].pop_front());
      end
      if (exp_qid.size() > 0) check("qid", m_qid_o, exp_qid.pop_front());
      if (exp_last.size() > 0) check("last", m_last_o, exp_last.pop_front());
    end
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++) begin
      if (ren_s[q]) begin
        if (fifo_m[q].size() > 0) void'(fifo_m[q].pop_front());
        else check("pop_when_empty", 32'(q), 32'hffff);
      end
    end
    drive();
    #1;
  endtask

  function automatic bit all_done();
    bit d;
    d = !m_valid_o;
    for (int q = 0; q < NQ; q++) begin
      if (fifo_m[q].size() != 0 || exp_d[q].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    cycle();
    check({tag, "_drain_in_budget"}, 32'(n < budget), 32'd1);
    check({tag, "_all_beats_seen"}, 32'(exp_qid.size()), 32'd0);
    check({tag, "_idle_after"}, 32'(busy_o), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid_o), 32'd0);
    check({tag, "_data"}, 32'(m_data_o), 32'd0);
    check({tag, "_qid"}, 32'(m_qid_o), 32'd0);
    check({tag, "_last"}, 32'(m_last_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_ren"}, 32'(ren_o), 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    m_ready_i = 1'b1;
    for (int q = 0; q < NQ; q++) begin
      fifo_m[q].delete();
      exp_d[q].delete();
    end
    exp_qid.delete();
    exp_last.delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [DW-1:0] held;
    rst_n = 1'b0;
    m_ready_i = 1'b1;
    empty_i = '1;
    aempty_i = '0;
    rdata_i = '0;
    drive();
    #1;
    check_zero("reset_async");
    reset_dut();
    check_zero("reset_release");

    // Single source, latency and aempty-terminated burst.
    load(2, 3, 8'd1);
    push_beats(2'd2, 3, 1'b1);
    cycle();
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_valid_lat1", 32'(m_valid_o), 32'd0);
    check("t1_ren", 32'(ren_o), 32'b0100);
    cycle();
    check("t1_valid_lat2", 32'(m_valid_o), 32'd1);
    check("t1_beat1", 32'(m_data_o), 32'd1);
    cycle();
    check("t1_beat2", 32'(m_data_o), 32'd2);
    cycle();
    check("t1_beat3", 32'(m_data_o), 32'd3);
    check("t1_last3", 32'(m_last_o), 32'd1);
    drain("t1", 20);

    // Burst limit: 0000 11 0000 00.
    reset_dut();
    load(0, 10, 8'h20);
    load(1, 2, 8'h40);
    push_beats(2'd0, 4, 1'b1);
    push_beats(2'd1, 2, 1'b1);
    push_beats(2'd0, 4, 1'b1);
    push_beats(2'd0, 2, 1'b1);
    drain("t2", 60);

    // Backpressure mid-burst.
    reset_dut();
    load(1, 6, 8'h50);
    push_beats(2'd1, 4, 1'b1);
    push_beats(2'd1, 2, 1'b1);
    repeat (3) cycle();
    m_ready_i = 1'b0;
    #1;
    held = m_data_o;
    check("t3_stall_valid0", 32'(m_valid_o), 32'd1);
    check("t3_stall_data0", 32'(held), 32'h51);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_stall_valid", 32'(m_valid_o), 32'd1);
      check("t3_stall_data", 32'(m_data_o), 32'(held));
      check("t3_stall_ren", 32'(ren_o), 32'd0);
    end
    m_ready_i = 1'b1;
    drain("t3", 40);

    // Fairness wrap: 8 entries each, grants rotate 0,1,2,3,0,1,2,3.
    reset_dut();
    for (int q = 0; q < NQ; q++) load(q, 8, DW'(q * 16));
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < NQ; q++) push_beats(QW'(q), BM, 1'b1);
    end
    drain("t4", 100);

    // Reset during the second beat of a burst from FIFO 3.
    reset_dut();
    load(3, 4, 8'h30);
    repeat (3) cycle();
    check("t5_second_beat", 32'(m_data_o), 32'h31);
    load(1, 2, 8'h10);
    rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    // Beats still inside the DUT are lost; expectations follow what the FIFOs still hold.
    for (int q = 0; q < NQ; q++) exp_d[q] = fifo_m[q];
    push_beats(2'd1, 2, 1'b1);
    push_beats(2'd3, 2, 1'b1);
    repeat (2) cycle();
    check_zero("t5_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("t5_first_grant_ren", 32'(ren_o), 32'b0010);
    drain("t5", 40);

`ifdef FIFO_RR_SCHED_PRIO_Q0_EN
    // Queue 0 wins every burst boundary while non-empty.
    reset_dut();
    load(0, 6, 8'h60);
    load(1, 3, 8'h70);
    push_beats(2'd0, 4, 1'b1);
    push_beats(2'd0, 2, 1'b1);
    push_beats(2'd1, 3, 1'b1);
    drain("t6", 40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
